// File: rtl/cache_req_scheduler_pkg.sv
// Shared encodings for the cache request scheduler: FSM states, response
// source codes and the memory fallback data pattern.
package cache_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PROMOTE,
    ST_MISS
  } sched_state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_L1   = 2'd1;
  localparam logic [1:0] SRC_L2   = 2'd2;
  localparam logic [1:0] SRC_MEM  = 2'd3;

  localparam logic [31:0] FALLBACK_DATA = 32'hCAFEBABE;

endpackage

// File: rtl/cache_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping, and reports the pointer value that follows the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         gnt_idx_o,
  output logic [2:0]         ptr_nxt_o,
  output logic               gnt_vld_o
);

  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    ptr_nxt_o = ptr_i;
    gnt_vld_o = 1'b0;
    found     = 1'b0;
    // First pass covers ptr..N-1; second pass wraps to the lowest index.
    for (int j = 0; j < NUM_REQ; j++) begin
      if (en_i && !found && req_i[j] && (j >= int'(ptr_i))) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = 3'(j);
        ptr_nxt_o = 3'((j + 1) % NUM_REQ);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (en_i && !found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = 3'(j);
        ptr_nxt_o = 3'((j + 1) % NUM_REQ);
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/cache_req_scheduler.sv
// Shares one L1/L2 cache read port among NUM_REQ requesters, one read in
// flight at a time, with promotion bubbles, miss latency and hit statistics.
module cache_req_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_LAT     = 1,
  parameter int MISS_PENALTY = 4,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [2:0]                    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                    rsp_src,
  output logic                          busy,
  output logic                          cache_read,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  input  logic [DATA_WIDTH-1:0]         cache_read_data,
  input  logic                          cache_l1_hit,
  input  logic                          cache_l2_hit,
  output logic [STAT_WIDTH-1:0]         stat_l1,
  output logic [STAT_WIDTH-1:0]         stat_l2,
  output logic [STAT_WIDTH-1:0]         stat_miss
);

  import cache_sched_pkg::*;

  localparam int LAT_W  = $clog2(RESP_LAT + 1);
  localparam int MISS_W = $clog2(MISS_PENALTY + 1);

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_e            state_q, state_d;
  logic [2:0]              ptr_q, ptr_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic [2:0]              id_q, id_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    cache_read_q, cache_read_d;
  logic [ADDR_WIDTH-1:0]   cache_addr_q, cache_addr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [2:0]              rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]              rsp_src_q, rsp_src_d;
  logic [STAT_WIDTH-1:0]   stat_l1_q, stat_l1_d;
  logic [STAT_WIDTH-1:0]   stat_l2_q, stat_l2_d;
  logic [STAT_WIDTH-1:0]   stat_miss_q, stat_miss_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [2:0]              arb_idx;
  logic [2:0]              arb_ptr_nxt;
  logic                    arb_vld;
  logic [ADDR_WIDTH-1:0]   addr_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (state_q == ST_IDLE),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .ptr_nxt_o (arb_ptr_nxt),
    .gnt_vld_o (arb_vld)
  );

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lat_d        = lat_q;
    miss_d       = miss_q;
    id_d         = id_q;
    data_d       = data_q;
    cache_read_d = 1'b0;
    cache_addr_d = cache_addr_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_src_d    = rsp_src_q;
    stat_l1_d    = stat_l1_q;
    stat_l2_d    = stat_l2_q;
    stat_miss_d  = stat_miss_q;
    unique case (state_q)
      ST_IDLE: begin
        // The read strobe is registered, so it is armed on the accept edge.
        if (arb_vld) begin
          id_d         = arb_idx;
          ptr_d        = arb_ptr_nxt;
          cache_addr_d = addr_sel;
          cache_read_d = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_d   = LAT_W'(RESP_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q <= LAT_W'(1)) begin
          if (cache_l1_hit) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_data_d  = cache_read_data;
            rsp_src_d   = SRC_L1;
            stat_l1_d   = sat_inc(stat_l1_q);
            state_d     = ST_IDLE;
          end else if (cache_l2_hit) begin
            data_d  = cache_read_data;
            state_d = ST_PROMOTE;
          end else begin
            data_d  = cache_read_data;
            miss_d  = MISS_W'(MISS_PENALTY);
            state_d = ST_MISS;
          end
        end
      end
      ST_PROMOTE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = data_q;
        rsp_src_d   = SRC_L2;
        stat_l2_d   = sat_inc(stat_l2_q);
        state_d     = ST_IDLE;
      end
      ST_MISS: begin
        miss_d = miss_q - 1'b1;
        if (miss_q <= MISS_W'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = data_q;
          rsp_src_d   = SRC_MEM;
          stat_miss_d = sat_inc(stat_miss_q);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      lat_q        <= '0;
      miss_q       <= '0;
      cache_read_q <= 1'b0;
      cache_addr_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_src_q    <= SRC_NONE;
      stat_l1_q    <= '0;
      stat_l2_q    <= '0;
      stat_miss_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lat_q        <= lat_d;
      miss_q       <= miss_d;
      cache_read_q <= cache_read_d;
      cache_addr_q <= cache_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_src_q    <= rsp_src_d;
      stat_l1_q    <= stat_l1_d;
      stat_l2_q    <= stat_l2_d;
      stat_miss_q  <= stat_miss_d;
    end
  end

  // Transaction payload only; meaningless until a request is accepted.
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    data_q <= data_d;
  end

  assign req_ready  = arb_gnt;
  assign busy       = (state_q != ST_IDLE);
  assign cache_read = cache_read_q;
  assign cache_addr = cache_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_src    = rsp_src_q;
  assign stat_l1    = stat_l1_q;
  assign stat_l2    = stat_l2_q;
  assign stat_miss  = stat_miss_q;

endmodule

// File: tb/tb_cache_req_scheduler.sv
// Directed bench for cache_req_scheduler with a registered one-cycle cache model.
module tb_cache_req_scheduler;

  import cache_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int SW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [1:0]        rsp_src;
  logic              busy;
  logic              cache_read;
  logic [AW-1:0]     cache_addr;
  logic [DW-1:0]     cache_read_data;
  logic              cache_l1_hit;
  logic              cache_l2_hit;
  logic [SW-1:0]     stat_l1, stat_l2, stat_miss;

  logic              cfg_l1, cfg_l2;
  logic [DW-1:0]     cfg_data;

  int checks   = 0;
  int failures = 0;

  cache_req_scheduler #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RESP_LAT(1), .MISS_PENALTY(4), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_src(rsp_src),
    .busy(busy), .cache_read(cache_read), .cache_addr(cache_addr),
    .cache_read_data(cache_read_data), .cache_l1_hit(cache_l1_hit), .cache_l2_hit(cache_l2_hit),
    .stat_l1(stat_l1), .stat_l2(stat_l2), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  // Cache outputs are valid only in the cycle after the read strobe.
  always @(posedge clk) begin
    if (cache_read) begin
      cache_l1_hit    <= cfg_l1;
      cache_l2_hit    <= cfg_l2;
      cache_read_data <= cfg_data;
    end else begin
      cache_l1_hit    <= 1'b0;
      cache_l2_hit    <= 1'b0;
      cache_read_data <= '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a negedge; returns 1 time unit after the negedge
  // that follows the response cycle.
  task automatic txn(input logic [1:0] vmask, input int exp_id, input logic [AW-1:0] a,
                     input logic l1, input logic l2, input logic [DW-1:0] d,
                     input int exp_lat, input logic [1:0] exp_src, input string tag);
    int lat;
    int nread;
    int read_at;
    cfg_l1   = l1;
    cfg_l2   = l2;
    cfg_data = d;
    req_addr = (exp_id == 1) ? {a, ~a} : {~a, a};
    req_valid = vmask;
    #1;
    chk({tag, ":ready"}, 32'(req_ready), 32'(1 << exp_id));
    lat = 0; nread = 0; read_at = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      #1;
      lat++;
      if (cache_read === 1'b1) begin
        nread++;
        read_at = lat;
        chk({tag, ":addr"}, 32'(cache_addr), 32'(a));
      end
    end while (rsp_valid !== 1'b1 && lat < 40);
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":reads"}, 32'(nread), 32'd1);
    chk({tag, ":read_at"}, 32'(read_at), 32'd1);
    chk({tag, ":id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, ":src"}, 32'(rsp_src), 32'(exp_src));
    chk({tag, ":data"}, rsp_data, d);
    @(negedge clk);
    #1;
    chk({tag, ":pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ngr;
    int nrsp;
    int cyc;
    int seen;
    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    cfg_l1 = 1'b0; cfg_l2 = 1'b0; cfg_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:cache_read", 32'(cache_read), 32'd0);
    chk("rst:cache_addr", 32'(cache_addr), 32'd0);
    chk("rst:rsp_src", 32'(rsp_src), 32'(SRC_NONE));
    chk("rst:stats", 32'({stat_l1, stat_l2, stat_miss}), 32'd0);
    rst_n = 1'b1;

    txn(2'b01, 0, 11'h010, 1'b1, 1'b0, 32'h1111_0001, 3, SRC_L1, "l1hit");
    chk("l1hit:stat_l1", 32'(stat_l1), 32'd1);
    txn(2'b10, 1, 11'h020, 1'b0, 1'b1, 32'h2222_0002, 4, SRC_L2, "l2hit");
    chk("l2hit:stat_l2", 32'(stat_l2), 32'd1);
    txn(2'b10, 1, 11'h030, 1'b0, 1'b0, FALLBACK_DATA, 7, SRC_MEM, "miss");
    chk("miss:stat_miss", 32'(stat_miss), 32'd1);
    chk("miss:addr_hold", 32'(cache_addr), 32'h030);

    // Both requesters held high; every later accept must coincide with a response.
    cfg_l1 = 1'b1; cfg_l2 = 1'b0; cfg_data = 32'h3333_0003;
    req_valid = 2'b11;
    ngr = 0; nrsp = 0; cyc = 0;
    #1;
    while (nrsp < 6 && cyc < 100) begin
      if (rsp_valid === 1'b1) begin
        chk("fair:rsp_id", 32'(rsp_id), 32'(nrsp % 2));
        nrsp++;
      end
      if (req_ready !== 2'b00) begin
        chk("fair:grant", 32'(req_ready), (ngr % 2 == 0) ? 32'd1 : 32'd2);
        if (ngr > 0) chk("fair:b2b", 32'(rsp_valid), 32'd1);
        ngr++;
      end
      @(negedge clk);
      if (ngr == 6) req_valid = '0;
      #1;
      cyc++;
    end
    chk("fair:responses", 32'(nrsp), 32'd6);
    chk("fair:grants", 32'(ngr), 32'd6);
    @(negedge clk);
    #1;
    chk("fair:stat_l1_sat", 32'(stat_l1), 32'd3);

    // Miss on requester 0 leaves the pointer at 1, then reset lands in MISS.
    cfg_l1 = 1'b0; cfg_l2 = 1'b0; cfg_data = FALLBACK_DATA;
    req_addr = {11'h7FF, 11'h040};
    req_valid = 2'b01;
    #1;
    chk("rstmiss:ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmiss:busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmiss:busy", 32'(busy), 32'd0);
    chk("rstmiss:stats", 32'({stat_l1, stat_l2, stat_miss}), 32'd0);
    chk("rstmiss:rsp_data", rsp_data, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
      #1;
    end
    chk("rstmiss:no_rsp", 32'(seen), 32'd0);

    // Pointer was reset, so requester 0 wins; then saturate the L1 counter.
    txn(2'b11, 0, 11'h050, 1'b1, 1'b0, 32'h4444_0001, 3, SRC_L1, "sat1");
    chk("sat1:stat_l1", 32'(stat_l1), 32'd1);
    txn(2'b01, 0, 11'h051, 1'b1, 1'b1, 32'h4444_0002, 3, SRC_L1, "sat2_both");
    chk("sat2:stat_l1", 32'(stat_l1), 32'd2);
    chk("sat2:stat_l2", 32'(stat_l2), 32'd0);
    txn(2'b01, 0, 11'h052, 1'b1, 1'b0, 32'h4444_0003, 3, SRC_L1, "sat3");
    chk("sat3:stat_l1", 32'(stat_l1), 32'd3);
    txn(2'b01, 0, 11'h053, 1'b1, 1'b0, 32'h4444_0004, 3, SRC_L1, "sat4");
    chk("sat4:stat_l1", 32'(stat_l1), 32'd3);
    txn(2'b01, 0, 11'h054, 1'b1, 1'b0, 32'h4444_0005, 3, SRC_L1, "sat5");
    chk("sat5:stat_l1", 32'(stat_l1), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_req_scheduler.md
Name: cache_req_scheduler

Overview:
- Shares one two-level 4-way cache system (L1 + L2, registered hit/data outputs, L2-to-L1 promotion the cycle after an L2 hit) between NUM_REQ requesters.
- Round-robin arbitration; only one cache read is in flight at a time.
- Sequences each read: issue, wait for the result, insert a promotion bubble after an L2 hit, model memory latency on a total miss.
- Routes the response back to the winning requester and keeps saturating hit/miss statistics.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 11, cache address width
DATA_WIDTH, 32, data width
RESP_LAT, 1, cycles from the cache read-strobe cycle to the cycle where the cache hit/data outputs are valid (>=1)
MISS_PENALTY, 4, extra cycles charged for a total miss (>=1)
STAT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset: one clock; synchronous, active-low
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NUM_REQ  one-hot accept pulse, combinational
rsp_valid  out  1  one-cycle response pulse, registered
rsp_id  out  3  requester index of the response
rsp_data  out  DATA_WIDTH  read data
rsp_src  out  2  response source: 1=L1, 2=L2, 3=memory fallback
busy  out  1  high when state != IDLE
cache_read  out  1  read strobe to the cache system
cache_addr  out  ADDR_WIDTH  address to the cache system
cache_read_data  in  DATA_WIDTH  cache read data
cache_l1_hit  in  1  cache L1 hit
cache_l2_hit  in  1  cache L2 hit
stat_l1  out  STAT_WIDTH  L1 hit count
stat_l2  out  STAT_WIDTH  L2 hit count
stat_miss  out  STAT_WIDTH  total miss count

Behaviour:
- Reset (rst_n low at an edge), including mid-transaction:
  - state=IDLE; rr pointer=0; lat/miss counters=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_src=0.
  - cache_read=0, cache_addr=0, stats=0.
  - An in-flight request is dropped with no response.
- States: IDLE, ISSUE, WAIT, PROMOTE, MISS.
- IDLE:
  - If any req_valid is set, grant the first valid requester at or after the rr pointer (wrapping).
  - req_ready[g]=1 in that cycle only; latch g and its address.
  - Pointer becomes (g+1) mod NUM_REQ. Next state ISSUE.
  - req_ready is 0 in all other states. A requester holds req_valid until it is accepted; dropping req_valid earlier has no effect.
- ISSUE: cache_read=1 and cache_addr=latched address for exactly one cycle. Load the lat counter with RESP_LAT. Next state WAIT.
- WAIT:
  - Decrement the lat counter. When it reaches 0 this cycle, sample the cache outputs.
  - cache_l1_hit=1: response with src=1; stat_l1++; next state IDLE. L1 has priority if both hits are asserted.
  - else cache_l2_hit=1: latch data; next state PROMOTE.
  - else: latch data (the memory fallback value); load the miss counter with MISS_PENALTY; next state MISS.
- PROMOTE: one bubble cycle so the L1 fill completes before the next read. Response with src=2; stat_l2++; next state IDLE.
- MISS: decrement the miss counter. At 0: response with src=3; stat_miss++; next state IDLE.
- Response registers load on the edge leaving WAIT, PROMOTE or MISS. rsp_valid is high exactly one cycle. IDLE may accept a new request in that same cycle.
- Latency from the accept cycle T (RESP_LAT=1):
  - L1 hit: rsp_valid at T+3.
  - L2 hit: rsp_valid at T+4.
  - Miss: rsp_valid at T+3+MISS_PENALTY.
- cache_addr holds its last value when idle. cache_read is never high on two consecutive cycles.
- Statistics saturate at all-ones and never wrap.

Decomposition:
- Package cache_sched_pkg holds:
  - the state encoding;
  - rsp_src codes SRC_NONE=0, SRC_L1=1, SRC_L2=2, SRC_MEM=3;
  - the fallback-data constant 32'hCAFEBABE, for benches.
- Sub-module rr_arbiter (NUM_REQ): request vector, pointer and enable in; one-hot grant, grant index and next pointer out.
- The FSM, counters and statistics stay in the top module.

Test Plan:
- Single L1 hit: req_valid=01, addr 0x010, model returns l1_hit with data 0x1111_0001. Required: req_ready=01 at T, cache_read at T+1, rsp_valid at T+3 with id=0, src=1, data=0x11110001, stat_l1=1.
- L2 hit then promotion: requester 1, addr 0x020, l2_hit with data 0x2222_0002. Required: rsp at T+4 with src=2, id=1; no cache_read during the PROMOTE cycle.
- Total miss: no hits, data 0xCAFEBABE, MISS_PENALTY=4. Required: rsp at T+7 with src=3, data 0xCAFEBABE, stat_miss=1.
- Fairness: both req_valid held high continuously for 6 transactions. Required grant order 0,1,0,1,0,1, and every back-to-back accept lands on the cycle rsp_valid is asserted.
- Reset mid-MISS: drop rst_n for one edge during MISS. Required: no rsp_valid, all stats 0, busy=0. The next request is granted to requester 0.
- Saturation: STAT_WIDTH=2, five L1 hits. Required: stat_l1 stays at 3.
